// File: rtl/arc4_pkg.sv
// arc4_pkg: shared state encodings, phase codes and S-memory widths for the ARC4 sequencer.
package arc4_pkg;
    localparam int S_AW = 8;
    localparam int S_DW = 8;
    typedef logic [2:0] arc4_seq_state_t;
    // GO states are odd and WAIT states even, so the phase falls out of (state+1)/2
    localparam arc4_seq_state_t ST_IDLE      = 3'd0;
    localparam arc4_seq_state_t ST_INIT_GO   = 3'd1;
    localparam arc4_seq_state_t ST_INIT_WAIT = 3'd2;
    localparam arc4_seq_state_t ST_KSA_GO    = 3'd3;
    localparam arc4_seq_state_t ST_KSA_WAIT  = 3'd4;
    localparam arc4_seq_state_t ST_PRGA_GO   = 3'd5;
    localparam arc4_seq_state_t ST_PRGA_WAIT = 3'd6;
    localparam arc4_seq_state_t ST_ERR       = 3'd7;
    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_INIT = 2'd1;
    localparam logic [1:0] PH_KSA  = 2'd2;
    localparam logic [1:0] PH_PRGA = 2'd3;
    function automatic logic [1:0] state_phase(input arc4_seq_state_t s);
        return (s == ST_IDLE || s == ST_ERR) ? PH_IDLE : 2'((4'(s) + 4'd1) >> 1);
    endfunction
endpackage

// File: rtl/arc4_seq_if.sv
// arc4_seq_if: upstream handshake, sub-block handshakes and S-memory port of the ARC4 sequencer.
interface arc4_seq_if #(parameter int KEY_W = 24);
    import arc4_pkg::*;
    logic             en, rdy, err;
    logic [1:0]       phase;
    logic [KEY_W-1:0] key_in, key_out;
    logic             init_en, ksa_en, prga_en;
    logic             init_rdy, ksa_rdy, prga_rdy;
    logic [S_AW-1:0]  init_addr, ksa_addr, prga_addr, s_addr;
    logic [S_DW-1:0]  init_wrdata, ksa_wrdata, prga_wrdata, s_wrdata;
    logic             init_wren, ksa_wren, prga_wren, s_wren;
    modport master (
        input  en, key_in, init_rdy, ksa_rdy, prga_rdy,
        input  init_addr, ksa_addr, prga_addr, init_wrdata, ksa_wrdata, prga_wrdata,
        input  init_wren, ksa_wren, prga_wren,
        output rdy, err, phase, key_out, init_en, ksa_en, prga_en, s_addr, s_wrdata, s_wren
    );
    modport slave (
        output en, key_in, init_rdy, ksa_rdy, prga_rdy,
        output init_addr, ksa_addr, prga_addr, init_wrdata, ksa_wrdata, prga_wrdata,
        output init_wren, ksa_wren, prga_wren,
        input  rdy, err, phase, key_out, init_en, ksa_en, prga_en, s_addr, s_wrdata, s_wren
    );
endinterface

// File: rtl/arc4_sport_mux.sv
// arc4_sport_mux: grants the single S-memory port to the sub-block owning the current phase.
module arc4_sport_mux
    import arc4_pkg::*;
(
    input  logic [1:0]      i_phase,
    input  logic [S_AW-1:0] i_init_addr,
    input  logic [S_AW-1:0] i_ksa_addr,
    input  logic [S_AW-1:0] i_prga_addr,
    input  logic [S_DW-1:0] i_init_wrdata,
    input  logic [S_DW-1:0] i_ksa_wrdata,
    input  logic [S_DW-1:0] i_prga_wrdata,
    input  logic            i_init_wren,
    input  logic            i_ksa_wren,
    input  logic            i_prga_wren,
    output logic [S_AW-1:0] o_s_addr,
    output logic [S_DW-1:0] o_s_wrdata,
    output logic            o_s_wren
);
    always_comb begin
        o_s_addr   = i_phase == PH_INIT ? i_init_addr   : i_phase == PH_KSA ? i_ksa_addr   : i_phase == PH_PRGA ? i_prga_addr   : '0;
        o_s_wrdata = i_phase == PH_INIT ? i_init_wrdata : i_phase == PH_KSA ? i_ksa_wrdata : i_phase == PH_PRGA ? i_prga_wrdata : '0;
        o_s_wren   = i_phase == PH_INIT ? i_init_wren   : i_phase == PH_KSA ? i_ksa_wren   : i_phase == PH_PRGA ? i_prga_wren   : 1'b0;
    end
endmodule

// File: rtl/arc4_seq.sv
// arc4_seq: runs init -> ksa -> prga once per accepted request, arbitrates the S port,
// latches the key for the run and aborts to ERR if any WAIT phase stalls.
module arc4_seq
    import arc4_pkg::*;
#(
    parameter int TIMEOUT = 4096,
    parameter int KEY_W   = 24
) (
    input logic         clk,
    input logic         rst,
    arc4_seq_if.master  m_if
);
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    arc4_seq_state_t  r_state, w_next;
    logic [WD_W-1:0]  r_wd;
    logic [KEY_W-1:0] r_key;
    logic [1:0]       w_phase;
    logic             w_idle, w_go, w_wait, w_sub_rdy, w_tmo;
    assign w_phase   = state_phase(r_state);
    assign w_idle    = r_state == ST_IDLE || r_state == ST_ERR;
    assign w_go      = r_state[0] && r_state != ST_ERR;
    assign w_wait    = !r_state[0] && r_state != ST_IDLE;
    assign w_sub_rdy = w_phase == PH_INIT ? m_if.init_rdy : w_phase == PH_KSA ? m_if.ksa_rdy : w_phase == PH_PRGA ? m_if.prga_rdy : 1'b0;
    assign w_tmo     = (TIMEOUT > 0) && (r_wd == WD_W'(TIMEOUT - 1));
    // completion beats a coinciding timeout because sub_rdy is tested first
    always_comb begin
        w_next = w_idle ? (m_if.en ? ST_INIT_GO : r_state) :
                 w_sub_rdy ? (r_state == ST_PRGA_WAIT ? ST_IDLE : r_state + 3'd1) :
                 (w_wait && w_tmo) ? ST_ERR : r_state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_wd    <= '0;
            r_key   <= '0;
        end else begin
            r_state <= w_next;
            r_wd    <= (w_wait && !w_sub_rdy) ? ((r_wd == '1) ? r_wd : r_wd + WD_W'(1)) : '0;
            if (w_idle && m_if.en)
                r_key <= m_if.key_in;
        end
    end
    assign m_if.rdy     = w_idle;
    assign m_if.err     = r_state == ST_ERR;
    assign m_if.phase   = w_phase;
    assign m_if.key_out = r_key;
    assign m_if.init_en = w_go && w_phase == PH_INIT && m_if.init_rdy;
    assign m_if.ksa_en  = w_go && w_phase == PH_KSA  && m_if.ksa_rdy;
    assign m_if.prga_en = w_go && w_phase == PH_PRGA && m_if.prga_rdy;
    arc4_sport_mux u_mux (
        .i_phase       (w_phase),
        .i_init_addr   (m_if.init_addr),
        .i_ksa_addr    (m_if.ksa_addr),
        .i_prga_addr   (m_if.prga_addr),
        .i_init_wrdata (m_if.init_wrdata),
        .i_ksa_wrdata  (m_if.ksa_wrdata),
        .i_prga_wrdata (m_if.prga_wrdata),
        .i_init_wren   (m_if.init_wren),
        .i_ksa_wren    (m_if.ksa_wren),
        .i_prga_wren   (m_if.prga_wren),
        .o_s_addr      (m_if.s_addr),
        .o_s_wrdata    (m_if.s_wrdata),
        .o_s_wren      (m_if.s_wren)
    );
endmodule

// File: tb/tb_arc4_seq.sv
// tb_arc4_seq: directed runs of the ARC4 sequencer with stubbed sub-blocks; a monitor
// pops expected en pulses and completions from a scoreboard queue.
module tb_arc4_seq;
    logic clk, rst;
    int   cyc, c_acc, n_chk, n_err;
    arc4_seq_if #(.KEY_W(24)) a_if();
    arc4_seq_if #(.KEY_W(24)) b_if();
    arc4_seq #(.TIMEOUT(4096), .KEY_W(24)) dut_a (.clk(clk), .rst(rst), .m_if(a_if.master));
    arc4_seq #(.TIMEOUT(100),  .KEY_W(24)) dut_b (.clk(clk), .rst(rst), .m_if(b_if.master));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // stubs 0..2 serve dut_a init/ksa/prga, 3..5 serve dut_b
    logic [5:0] s_en, r_rdy, g_rdy, hold, hang;
    int         len[6], cnt[6];
    assign s_en  = {b_if.prga_en, b_if.ksa_en, b_if.init_en, a_if.prga_en, a_if.ksa_en, a_if.init_en};
    assign g_rdy = r_rdy & ~hold;
    assign {b_if.prga_rdy, b_if.ksa_rdy, b_if.init_rdy, a_if.prga_rdy, a_if.ksa_rdy, a_if.init_rdy} = g_rdy;
    always @(posedge clk)
        for (int k = 0; k < 6; k++)
            if (rst) begin
                r_rdy[k] <= 1'b1;
                cnt[k]   <= 0;
            end else if (s_en[k] && g_rdy[k]) begin
                r_rdy[k] <= 1'b0;
                cnt[k]   <= len[k] - 1;
            end else if (!r_rdy[k] && !hang[k]) begin
                if (cnt[k] <= 1) r_rdy[k] <= 1'b1;
                else cnt[k] <= cnt[k] - 1;
            end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // kind: 0 init_en, 1 ksa_en, 2 prga_en, 3 rdy re-raised; rel counted from the accept edge
    typedef struct {int kind; int rel; logic [23:0] key;} exp_t;
    exp_t q[$];
    task automatic push(input int g, input int li, input int lk, input int lp, input logic [23:0] k, input bit done);
        q.push_back('{0, g, k});
        q.push_back('{1, g + li + 1, k});
        q.push_back('{2, g + li + lk + 2, k});
        if (done) q.push_back('{3, g + li + lk + lp + 3, k});
    endtask
    task automatic evt(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_unexpected: got event %0d at cycle %0d, want none", kind, cyc - c_acc);
        end else begin
            e = q.pop_front();
            chk("ev_kind", kind, e.kind);
            chk("ev_cycle", cyc - c_acc, e.rel);
            chk("ev_key", {8'h0, a_if.key_out}, {8'h0, e.key});
            chk("ev_phase", {30'h0, a_if.phase}, e.kind == 3 ? 0 : e.kind + 1);
            chk("ev_err", {31'h0, a_if.err}, 0);
        end
    endtask
    logic prev_rdy = 1'b1, rst_seen;
    always @(posedge clk) rst_seen <= rst;
    always @(negedge clk) begin
        if (a_if.init_en) evt(0);
        if (a_if.ksa_en) evt(1);
        if (a_if.prga_en) evt(2);
        if (a_if.rdy && !prev_rdy && !rst_seen) evt(3);
        prev_rdy = a_if.rdy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic start(input logic [23:0] k);
        a_if.key_in = k;
        a_if.en = 1'b1;
        tick();
        a_if.en = 1'b0;
        c_acc = cyc;
    endtask
    task automatic wait_phase(input logic [1:0] p, input int bound);
        int n = 0;
        while (a_if.phase != p && n < bound) begin
            tick();
            n++;
        end
        chk("wait_phase", {30'h0, a_if.phase}, {30'h0, p});
    endtask
    task automatic wait_rdy(input int bound);
        int n = 0;
        while (!a_if.rdy && n < bound) begin
            tick();
            n++;
        end
        chk("wait_rdy", {31'h0, a_if.rdy}, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int m;
        n_chk = 0; n_err = 0; c_acc = 0;
        rst = 1'b1; hold = '0; hang = 6'b010000;
        len = '{256, 768, 40, 3, 3, 3};
        {a_if.en, a_if.key_in, a_if.init_wren, a_if.ksa_wren, a_if.prga_wren} = '0;
        {b_if.en, b_if.key_in, b_if.init_wren, b_if.ksa_wren, b_if.prga_wren} = '0;
        {a_if.ksa_addr, a_if.prga_addr, a_if.init_wrdata, a_if.ksa_wrdata, a_if.prga_wrdata} = '0;
        {b_if.init_addr, b_if.ksa_addr, b_if.prga_addr, b_if.init_wrdata, b_if.ksa_wrdata, b_if.prga_wrdata} = '0;
        a_if.init_addr = 8'hAA;
        a_if.init_wren = 1'b1;
        tick(); tick();
        chk("rst_rdy", {31'h0, a_if.rdy}, 1);
        chk("rst_err", {31'h0, a_if.err}, 0);
        chk("rst_phase", {30'h0, a_if.phase}, 0);
        chk("rst_key", {8'h0, a_if.key_out}, 0);
        chk("rst_ens", {29'h0, a_if.init_en, a_if.ksa_en, a_if.prga_en}, 0);
        chk("idle_s_addr", {24'h0, a_if.s_addr}, 0);
        chk("idle_s_wren", {31'h0, a_if.s_wren}, 0);
        rst = 1'b0;
        a_if.init_wren = 1'b0;

        // normal run with a busy en and key change during KSA, plus grant isolation
        push(0, 256, 768, 40, 24'h000018, 1);
        start(24'h000018);
        wait_phase(2'd2, 400);
        tick(); tick(); tick();
        a_if.key_in = 24'hFFFFFF;
        a_if.en = 1'b1;
        tick();
        a_if.en = 1'b0;
        chk("busy_key", {8'h0, a_if.key_out}, 32'h18);
        chk("busy_phase", {30'h0, a_if.phase}, 2);
        a_if.init_addr = 8'hAA; a_if.init_wren = 1'b1;
        a_if.ksa_addr = 8'h05; a_if.ksa_wrdata = 8'h33; a_if.ksa_wren = 1'b0;
        #1;
        chk("ksa_s_addr", {24'h0, a_if.s_addr}, 32'h05);
        chk("ksa_s_wrdata", {24'h0, a_if.s_wrdata}, 32'h33);
        chk("ksa_s_wren", {31'h0, a_if.s_wren}, 0);
        wait_phase(2'd3, 1000);
        a_if.prga_addr = 8'hC3; a_if.prga_wrdata = 8'h5A; a_if.prga_wren = 1'b1;
        #1;
        chk("prga_s_addr", {24'h0, a_if.s_addr}, 32'hC3);
        chk("prga_s_wrdata", {24'h0, a_if.s_wrdata}, 32'h5A);
        chk("prga_s_wren", {31'h0, a_if.s_wren}, 1);
        a_if.prga_addr = 8'h7E; a_if.prga_wren = 1'b0;
        #1;
        chk("prga_s_addr2", {24'h0, a_if.s_addr}, 32'h7E);
        chk("prga_s_wren2", {31'h0, a_if.s_wren}, 0);
        wait_rdy(200);
        chk("rdy_low_cycles", cyc - c_acc, 1067);
        a_if.init_wren = 1'b0;

        // reset in the middle of PRGA
        len[0] = 4; len[1] = 5; len[2] = 30;
        push(0, 4, 5, 30, 24'h123456, 0);
        start(24'h123456);
        wait_phase(2'd3, 50);
        tick(); tick(); tick();
        a_if.prga_wren = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_rdy", {31'h0, a_if.rdy}, 1);
        chk("mrst_phase", {30'h0, a_if.phase}, 0);
        chk("mrst_s_wren", {31'h0, a_if.s_wren}, 0);
        chk("mrst_key", {8'h0, a_if.key_out}, 0);
        chk("mrst_prga_en", {31'h0, a_if.prga_en}, 0);
        a_if.prga_wren = 1'b0;

        // init_rdy held low for 10 cycles after the request
        len[0] = 5; len[1] = 6; len[2] = 7;
        hold[0] = 1'b1;
        push(10, 5, 6, 7, 24'hABCDEF, 1);
        start(24'hABCDEF);
        repeat (5) tick();
        chk("slow_phase", {30'h0, a_if.phase}, 1);
        chk("slow_rdy", {31'h0, a_if.rdy}, 0);
        chk("slow_init_en", {31'h0, a_if.init_en}, 0);
        repeat (5) tick();
        hold[0] = 1'b0;
        wait_rdy(100);

        // watchdog on dut_b (TIMEOUT=100) with a ksa stub that never returns
        b_if.key_in = 24'h00AB12;
        b_if.en = 1'b1;
        tick();
        b_if.en = 1'b0;
        m = 0;
        do begin @(negedge clk); m++; end while (!b_if.ksa_en && m < 50);
        chk("wd_ksa_en", {31'h0, b_if.ksa_en}, 1);
        m = 0;
        do begin @(negedge clk); m++; end while (!b_if.rdy && m < 200);
        chk("wd_cycles", m, 101);
        chk("wd_err", {31'h0, b_if.err}, 1);
        chk("wd_phase", {30'h0, b_if.phase}, 0);
        repeat (3) @(negedge clk);
        chk("wd_err_hold", {31'h0, b_if.err}, 1);
        b_if.en = 1'b1;
        @(posedge clk);
        #1;
        b_if.en = 1'b0;
        chk("wd_restart_err", {31'h0, b_if.err}, 0);
        chk("wd_restart_phase", {30'h0, b_if.phase}, 1);
        chk("wd_restart_rdy", {31'h0, b_if.rdy}, 0);
        @(negedge clk);
        chk("wd_restart_init_en", {31'h0, b_if.init_en}, 1);

        tick();
        chk("sb_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
